// File: rtl/mips_pipe_pkg.sv
// Shared types for the pipeline hazard unit: operand-mux select codes and the
// shadow record that tracks each in-flight instruction through EX, MEM and WB.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register addresses are zero-extended into a fixed-width field so the record
  // type can live in the package; REG_AW must not exceed this width.
  localparam int unsigned SHADOW_AW = 8;
  typedef logic [SHADOW_AW-1:0] shadow_addr_t;

  typedef struct packed {
    logic         valid;
    shadow_addr_t rs;
    shadow_addr_t rt;
    logic         uses_rs;
    logic         uses_rt;
    shadow_addr_t dst;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
  } shadow_entry_t;

  function automatic logic [1:0] fwd_select(input logic i_mem_hit, input logic i_wb_hit);
    if (i_mem_hit) return FWD_MEM;
    if (i_wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// One producer/consumer comparison: true when the producer writes a non-zero
// register that the consumer actually reads.
module hazard_match
  import mips_pipe_pkg::*;
(
  input  logic                 i_prod_valid,
  input  logic                 i_prod_reg_write,
  input  logic [SHADOW_AW-1:0] i_prod_dst,
  input  logic                 i_cons_valid,
  input  logic                 i_cons_uses,
  input  logic [SHADOW_AW-1:0] i_cons_src,
  output logic                 o_match
);

  assign o_match = i_prod_valid & i_prod_reg_write & i_cons_valid & i_cons_uses &
                   (i_prod_dst != '0) & (i_prod_dst == i_cons_src);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS-style pipeline.
// Shadows the EX/MEM/WB instructions and derives stall/bubble/flush/forward selects.
module pipeline_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FORWARDING = 1,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              redirect,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_store,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] i_val);
    if (i_val == '1) return i_val;
    return i_val + CNT_W'(1);
  endfunction

  shadow_entry_t    w_id;
  shadow_entry_t    w_id_next;
  shadow_entry_t    r_ex;
  shadow_entry_t    r_mem;
  shadow_entry_t    r_wb;
  shadow_entry_t    w_prod [3];
  logic             w_id_hit [3][2];
  logic             w_ex_hit [2][2];
  logic [2:0]       w_id_any;
  logic             w_hazard;
  logic             w_store_hit;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_unused_wb;

  always_comb begin
    w_id           = '0;
    w_id.valid     = id_valid;
    w_id.rs        = shadow_addr_t'(id_rs);
    w_id.rt        = shadow_addr_t'(id_rt);
    w_id.uses_rs   = id_uses_rs;
    w_id.uses_rt   = id_uses_rt;
    w_id.dst       = shadow_addr_t'(id_dst);
    w_id.reg_write = id_reg_write;
    w_id.mem_read  = id_mem_read;
    w_id.mem_write = id_mem_write;
    w_id_next       = w_id;
    w_id_next.valid = id_valid & ~bubble;
  end

  assign w_prod[0] = r_ex;
  assign w_prod[1] = r_mem;
  assign w_prod[2] = r_wb;

  // ID sources against every in-flight producer
  for (genvar p = 0; p < 3; p++) begin : g_id_prod
    for (genvar s = 0; s < 2; s++) begin : g_src
      hazard_match u_match (
        .i_prod_valid     (w_prod[p].valid),
        .i_prod_reg_write (w_prod[p].reg_write),
        .i_prod_dst       (w_prod[p].dst),
        .i_cons_valid     (w_id.valid),
        .i_cons_uses      ((s == 0) ? w_id.uses_rs : w_id.uses_rt),
        .i_cons_src       ((s == 0) ? w_id.rs : w_id.rt),
        .o_match          (w_id_hit[p][s])
      );
    end
    assign w_id_any[p] = w_id_hit[p][0] | w_id_hit[p][1];
  end

  // EX sources against MEM and WB for the operand muxes
  for (genvar p = 0; p < 2; p++) begin : g_ex_prod
    for (genvar s = 0; s < 2; s++) begin : g_src
      hazard_match u_match (
        .i_prod_valid     (w_prod[p+1].valid),
        .i_prod_reg_write (w_prod[p+1].reg_write),
        .i_prod_dst       (w_prod[p+1].dst),
        .i_cons_valid     (r_ex.valid),
        .i_cons_uses      ((s == 0) ? r_ex.uses_rs : r_ex.uses_rt),
        .i_cons_src       ((s == 0) ? r_ex.rs : r_ex.rt),
        .o_match          (w_ex_hit[p][s])
      );
    end
  end

  // Store data is consumed late in MEM, so the store itself qualifies the rt read.
  hazard_match u_store_match (
    .i_prod_valid     (r_wb.valid),
    .i_prod_reg_write (r_wb.reg_write),
    .i_prod_dst       (r_wb.dst),
    .i_cons_valid     (r_mem.valid),
    .i_cons_uses      (r_mem.mem_write),
    .i_cons_src       (r_mem.rt),
    .o_match          (w_store_hit)
  );

  always_comb begin
    w_hazard = 1'b0;
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    if (FORWARDING != 0) begin
      w_hazard = r_ex.mem_read & w_id_any[0];
      fwd_a    = fwd_select(w_ex_hit[0][0], w_ex_hit[1][0]);
      fwd_b    = fwd_select(w_ex_hit[0][1], w_ex_hit[1][1]);
    end else begin
      w_hazard = w_id_any[0] | w_id_any[1] | ((RF_BYPASS == 0) & w_id_any[2]);
    end
  end

  // A redirect kills the ID instruction anyway, so it overrides any stall.
  assign stall       = w_hazard & ~redirect;
  assign bubble      = w_hazard | redirect;
  assign flush       = redirect;
  assign fwd_store   = w_store_hit;
  assign stall_count = r_stall_count;
  assign w_unused_wb = ^r_wb;

  // Shadow advance: ID -> EX -> MEM -> WB
  always_ff @(posedge clk) begin
    r_ex  <= w_id_next;
    r_mem <= r_ex;
    r_wb  <= r_mem;
    if (!reset) begin
      r_ex.valid    <= 1'b0;
      r_mem.valid   <= 1'b0;
      r_wb.valid    <= 1'b0;
      r_stall_count <= '0;
    end else if (stall) begin
      r_stall_count <= sat_inc(r_stall_count);
    end
  end

endmodule
